verificador_de_senha: RTL and testbench

VERIFICADOR_DE_SENHA -- requirements
Module: verificador_de_senha

---
 rtl/verificador_de_senha.sv | 161 ++++++++++++++++
 tb/tb_verificador_de_senha.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/verificador_de_senha.sv
// Purpose : keypad password checker with four programmable slots and lockout after repeated failures.
// Latency : from the capture edge, abrir is sampled at edge 3+k (match on slot k), erro at edge 6 (no match) or 2 (malformed).
// Backpressure: none; digitos_valid is taken only in IDLE and dropped elsewhere, and teclado_enable is low while locked.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   digitos_value/valid packed keypad entry and its strobe
//   cfg_wr/idx/senha    slot write request (IDLE only), cfg_ack one-cycle acknowledge
//   abrir, erro         one-cycle unlock / failed-attempt pulses
//   slot_ok             index of the last matched slot
//   tentativas          consecutive failure count
//   bloqueado           lockout active; teclado_enable is its complement
//
// Code layout: 20 digits of 4 bits, digit 0 in bits [79:76] and digit 19 (newest key) in bits [3:0].
// A well-formed code occupies the N lowest nibbles (4..12 of them, none equal to F), all other nibbles F.
module verificador_de_senha #(
    parameter int          MAX_TENT     = 3,
    parameter int          LOCK_CYCLES  = 5000,
    parameter logic [79:0] SENHA_PADRAO = {{16{4'hF}}, 16'h1234}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] digitos_value,
    input  logic        digitos_valid,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_idx,
    input  logic [79:0] cfg_senha,
    output logic        cfg_ack,
    output logic        abrir,
    output logic        erro,
    output logic [1:0]  slot_ok,
    output logic [1:0]  tentativas,
    output logic        bloqueado,
    output logic        teclado_enable
);

    typedef enum logic [2:0] {
        IDLE, CHECK, COMPARE, OPEN, FAIL, LOCKED
    } estado_t;

    localparam logic [1:0]  MAX_T     = 2'(MAX_TENT);
    localparam logic [12:0] LOCK_LAST = 13'(LOCK_CYCLES - 1);
    localparam logic [79:0] TUDO_B    = {20{4'hB}};
    localparam logic [79:0] TUDO_E    = {20{4'hE}};

    estado_t     state, state_nxt;
    logic [79:0] codigo;
    logic [79:0] slot_senha [4];
    logic [3:0]  slot_vld;
    logic [1:0]  ptr;
    logic [12:0] lock_cnt;
    logic [1:0]  tent_nxt;
    logic        casou;
    logic        cfg_aceito;

    // True when the non-F nibbles form a contiguous run of 4..12 starting at the LSB nibble.
    function automatic logic bem_formada(input logic [79:0] s);
        logic [19:0] nao_f;
        logic        ok;
        for (int p = 0; p < 20; p++) begin
            nao_f[p] = (s[p*4 +: 4] != 4'hF);
        end
        ok = 1'b0;
        for (int n = 4; n <= 12; n++) begin
            if (nao_f == 20'((21'd1 << n) - 21'd1)) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    assign casou      = slot_vld[ptr] && (slot_senha[ptr] == codigo);
    assign tent_nxt   = (tentativas == MAX_T) ? MAX_T : tentativas + 2'd1;
    // An entry strobe in the same IDLE cycle takes priority over a slot write.
    assign cfg_aceito = (state == IDLE) && cfg_wr && !digitos_valid;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (digitos_valid) state_nxt = CHECK;
            end
            CHECK: begin
                if (codigo == TUDO_B || codigo == TUDO_E) state_nxt = IDLE;
                else if (!bem_formada(codigo))            state_nxt = FAIL;
                else                                      state_nxt = COMPARE;
            end
            COMPARE: begin
                if (casou)              state_nxt = OPEN;
                else if (ptr == 2'd3)   state_nxt = FAIL;
            end
            OPEN: state_nxt = IDLE;
            FAIL: begin
                state_nxt = (tent_nxt == MAX_T) ? LOCKED : IDLE;
            end
            LOCKED: begin
                if (lock_cnt == LOCK_LAST) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        abrir          = (state == OPEN);
        erro           = (state == FAIL);
        bloqueado      = (state == LOCKED);
        teclado_enable = (state != LOCKED);
    end

    // Datapath: captured code, slot pointer, counters, slot store
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            codigo        <= '1;
            ptr           <= 2'd0;
            slot_ok       <= 2'd0;
            tentativas    <= 2'd0;
            lock_cnt      <= 13'd0;
            cfg_ack       <= 1'b0;
            slot_senha[0] <= SENHA_PADRAO;
            slot_senha[1] <= '1;
            slot_senha[2] <= '1;
            slot_senha[3] <= '1;
            slot_vld      <= 4'b0001;
        end else begin
            cfg_ack <= cfg_aceito;
            if (cfg_aceito) begin
                slot_senha[cfg_idx] <= cfg_senha;
                slot_vld[cfg_idx]   <= bem_formada(cfg_senha);
            end

            if (state == IDLE && digitos_valid) codigo <= digitos_value;

            if (state == CHECK)        ptr <= 2'd0;
            else if (state == COMPARE) ptr <= ptr + 2'd1;

            if (state == COMPARE && casou) slot_ok <= ptr;

            case (state)
                OPEN:    tentativas <= 2'd0;
                FAIL:    tentativas <= tent_nxt;
                LOCKED:  if (lock_cnt == LOCK_LAST) tentativas <= 2'd0;
                default: ;
            endcase

            if (state == LOCKED && lock_cnt != LOCK_LAST) lock_cnt <= lock_cnt + 13'd1;
            else                                          lock_cnt <= 13'd0;
        end
    end

endmodule

// File: tb/tb_verificador_de_senha.sv
// Directed stimulus; expected pulses (kind, sample cycle, slot) are queued by the
// stimulus and popped by an independent monitor whenever cfg_ack/abrir/erro is high.
// A pulse "in cycle n" after a capture at edge E is the level sampled at edge E+n,
// i.e. it is present while cyc == E+n-1.
module tb_verificador_de_senha;

    logic        clk = 1'b0;
    logic        rst;
    logic [79:0] digitos_value;
    logic        digitos_valid;
    logic        cfg_wr;
    logic [1:0]  cfg_idx;
    logic [79:0] cfg_senha;
    logic        cfg_ack;
    logic        abrir;
    logic        erro;
    logic [1:0]  slot_ok;
    logic [1:0]  tentativas;
    logic        bloqueado;
    logic        teclado_enable;

    verificador_de_senha #(
        .MAX_TENT    (3),
        .LOCK_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .digitos_value  (digitos_value),
        .digitos_valid  (digitos_valid),
        .cfg_wr         (cfg_wr),
        .cfg_idx        (cfg_idx),
        .cfg_senha      (cfg_senha),
        .cfg_ack        (cfg_ack),
        .abrir          (abrir),
        .erro           (erro),
        .slot_ok        (slot_ok),
        .tentativas     (tentativas),
        .bloqueado      (bloqueado),
        .teclado_enable (teclado_enable)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    localparam int K_ACK   = 1;
    localparam int K_ABRIR = 2;
    localparam int K_ERRO  = 3;

    localparam logic [79:0] C1234  = {{16{4'hF}}, 16'h1234};
    localparam logic [79:0] C98765 = {{15{4'hF}}, 20'h98765};
    localparam logic [79:0] C123   = {{17{4'hF}}, 12'h123};
    localparam logic [79:0] C4321  = {{16{4'hF}}, 16'h4321};
    localparam logic [79:0] C5555  = {{16{4'hF}}, 16'h5555};
    localparam logic [79:0] C0000  = {{16{4'hF}}, 16'h0000};
    localparam logic [79:0] C12D   = {{8{4'hF}}, 48'h123456789ABC};
    localparam logic [79:0] C13D   = {{7{4'hF}}, 52'h123456789ABCD};
    localparam logic [79:0] CB     = {20{4'hB}};
    localparam logic [79:0] CE     = {20{4'hE}};

    typedef struct {
        int         kind;
        int         quando;
        logic [1:0] slot;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nome, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nome, act, exp, cyc);
        end
    endtask

    task automatic pop(input int kind);
        exp_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse", kind, cyc);
        end else begin
            e = q.pop_front();
            check("pulse_kind", kind, e.kind);
            check("pulse_cycle", cyc, e.quando);
            if (kind == K_ABRIR) check("slot_ok", int'(slot_ok), int'(e.slot));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (cfg_ack) pop(K_ACK);
        if (abrir)   pop(K_ABRIR);
        if (erro)    pop(K_ERRO);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Strobe one entry; kind 0 means no pulse is expected.
    task automatic entry(input logic [79:0] v, input int kind, input int lat, input logic [1:0] slot);
        @(negedge clk);
        digitos_value = v;
        digitos_valid = 1'b1;
        if (kind != 0) q.push_back('{kind, cyc + lat, slot});
        @(negedge clk);
        digitos_valid = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic [79:0] v);
        @(negedge clk);
        cfg_wr    = 1'b1;
        cfg_idx   = idx;
        cfg_senha = v;
        q.push_back('{K_ACK, cyc + 1, 2'd0});
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_abrir"},      int'(abrir), 0);
        check({tag, "_erro"},       int'(erro), 0);
        check({tag, "_cfg_ack"},    int'(cfg_ack), 0);
        check({tag, "_bloqueado"},  int'(bloqueado), 0);
        check({tag, "_teclado_en"}, int'(teclado_enable), 1);
        check({tag, "_slot_ok"},    int'(slot_ok), 0);
        check({tag, "_tentativas"}, int'(tentativas), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n_lock;
        int te_bad;

        rst           = 1'b1;
        digitos_value = '1;
        digitos_valid = 1'b0;
        cfg_wr        = 1'b0;
        cfg_idx       = 2'd0;
        cfg_senha     = '1;
        idle(3);
        check_reset("reset");
        rst = 1'b0;
        idle(2);

        // Default code in slot 0
        entry(C1234, K_ABRIR, 3, 2'd0); idle(8);
        check("tent_after_open", int'(tentativas), 0);

        // Write slot 2, then match it
        cfg_write(2'd2, C98765); idle(2);
        entry(C98765, K_ABRIR, 5, 2'd2); idle(8);

        // Malformed (3 digits) then wrong code
        entry(C123, K_ERRO, 2, 2'd0); idle(8);
        check("tent_after_malformed", int'(tentativas), 1);
        entry(C4321, K_ERRO, 6, 2'd0); idle(8);
        check("tent_after_wrong", int'(tentativas), 2);

        // Cancel and timeout: no pulse, count held
        entry(CB, 0, 0, 2'd0); idle(8);
        check("tent_after_cancel", int'(tentativas), 2);
        entry(CE, 0, 0, 2'd0); idle(8);
        check("tent_after_timeout", int'(tentativas), 2);

        entry(C1234, K_ABRIR, 3, 2'd0); idle(8);
        check("tent_cleared_by_open", int'(tentativas), 0);

        // Collision: entry wins, write to slot 1 dropped
        @(negedge clk);
        digitos_value = C1234;
        digitos_valid = 1'b1;
        cfg_wr        = 1'b1;
        cfg_idx       = 2'd1;
        cfg_senha     = C5555;
        q.push_back('{K_ABRIR, cyc + 3, 2'd0});
        @(negedge clk);
        digitos_valid = 1'b0;
        cfg_wr        = 1'b0;
        idle(8);
        entry(C5555, K_ERRO, 6, 2'd0); idle(8);
        check("tent_after_dropped_slot", int'(tentativas), 1);
        entry(C1234, K_ABRIR, 3, 2'd0); idle(8);

        // Length boundaries: 12 digits valid, 13 malformed
        cfg_write(2'd3, C12D); idle(2);
        entry(C12D, K_ABRIR, 6, 2'd3); idle(8);
        entry(C13D, K_ERRO, 2, 2'd0); idle(8);
        check("tent_after_13_digits", int'(tentativas), 1);
        entry(C1234, K_ABRIR, 3, 2'd0); idle(8);

        // Lockout after three failures
        entry(C0000, K_ERRO, 6, 2'd0); idle(8);
        entry(C0000, K_ERRO, 6, 2'd0); idle(8);
        entry(C0000, K_ERRO, 6, 2'd0);
        w = 0;
        while (!bloqueado && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("lock_started", int'(bloqueado), 1);
        check("tent_during_lock", int'(tentativas), 3);
        n_lock = 0;
        te_bad = 0;
        w      = 0;
        while (bloqueado && w < 100) begin
            n_lock++;
            if (teclado_enable) te_bad++;
            // Correct code strobed mid-lockout must be ignored
            digitos_value = C1234;
            digitos_valid = (n_lock == 3);
            @(negedge clk);
            w++;
        end
        digitos_valid = 1'b0;
        check("lock_length", n_lock, 16);
        check("teclado_en_low_in_lock", te_bad, 0);
        check("tent_after_lock", int'(tentativas), 0);
        check("teclado_en_after_lock", int'(teclado_enable), 1);
        idle(4);
        entry(C1234, K_ABRIR, 3, 2'd0); idle(8);

        // Reset during COMPARE
        entry(C98765, K_ABRIR, 5, 2'd2); idle(8);
        entry(C98765, 0, 0, 2'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset("mid_reset");
        idle(2);
        rst = 1'b0;
        idle(10);
        check("slot_ok_after_reset", int'(slot_ok), 0);
        // Slot 2 is invalid again after reset
        entry(C98765, K_ERRO, 6, 2'd0); idle(8);
        check("tent_after_reset_fail", int'(tentativas), 1);

        check("queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
